// File: rtl/debounce_event_counter.sv
// Multi-channel switch front end: synchroniser, prescaled debouncer with hysteresis,
// press/release pulses and per-channel press counters with wrap flag, all on clk.
module debounce_event_counter #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned PRESC_W    = 16,
   parameter int unsigned DEPTH      = 5,
   parameter int unsigned CNT_W      = 4,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH-1:0]         sw_in,
   input  logic                    cnt_en,
   input  logic                    clr,
   output logic [N_CH-1:0]         sw_level,
   output logic [N_CH-1:0]         press_pulse,
   output logic [N_CH-1:0]         release_pulse,
   output logic [N_CH*CNT_W-1:0]   count,
   output logic [N_CH-1:0]         wrap
);

   localparam logic             IDLE    = ACTIVE_LOW;
   localparam logic [N_CH-1:0]  IDLE_V  = {N_CH{IDLE}};
   localparam logic [DEPTH-1:0] IDLE_SH = {DEPTH{IDLE}};

   logic [N_CH-1:0]             sync1;
   logic [N_CH-1:0]             sync2;
   logic [PRESC_W-1:0]          presc;
   logic                        tick_c;
   logic [N_CH-1:0][DEPTH-1:0]  sh;
   logic [N_CH-1:0]             level_nxt_c;
   logic [N_CH-1:0]             changed_c;
   logic [N_CH-1:0]             press_c;
   logic [N_CH-1:0]             release_c;
   logic [N_CH-1:0][CNT_W-1:0]  cnt_q;

   // Two-flop synchroniser per channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= IDLE_V;
         sync2 <= IDLE_V;
      end else begin
         sync1 <= sw_in;
         sync2 <= sync1;
      end
   end

   // Shared free-running sample prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) presc <= '0;
      else        presc <= presc + PRESC_W'(1);
   end

   assign tick_c = &presc;

   // Hysteresis: leave current level only when every stored sample disagrees
   always_comb begin
      level_nxt_c = sw_level;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (tick_c) level_nxt_c[i] = sw_level[i] ? (|sh[i]) : (&sh[i]);
      end
      changed_c = sw_level ^ level_nxt_c;
      press_c   = changed_c & (level_nxt_c ^ IDLE_V);
      release_c = changed_c & ~(level_nxt_c ^ IDLE_V);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh            <= {N_CH{IDLE_SH}};
         sw_level      <= IDLE_V;
         press_pulse   <= '0;
         release_pulse <= '0;
      end else begin
         if (tick_c) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
               sh[i] <= {sh[i][DEPTH-2:0], sync2[i]};
            end
         end
         sw_level      <= level_nxt_c;
         press_pulse   <= press_c;
         release_pulse <= release_c;
      end
   end

   // Press counters update on the same edge that raises press_pulse; clr wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         wrap  <= '0;
      end else if (clr) begin
         cnt_q <= '0;
         wrap  <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (press_c[i] && cnt_en) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
               wrap[i]  <= &cnt_q[i];
            end else begin
               wrap[i]  <= 1'b0;
            end
         end
      end
   end

   assign count = cnt_q;

endmodule

// File: tb/tb_debounce_event_counter.sv
// Scoreboard bench for debounce_event_counter: a tick-level reference model queues expected
// pulse events; a negedge monitor pops and compares them with the DUT outputs.
module tb_debounce_event_counter;

   localparam int N_CH    = 2;
   localparam int PRESC_W = 3;
   localparam int DEPTH   = 5;
   localparam int CNT_W   = 4;
   localparam int TICK    = 8;

   logic                  clk;
   logic                  rst_n;
   logic [N_CH-1:0]       sw_in;
   logic                  cnt_en;
   logic                  clr;
   logic [N_CH-1:0]       sw_level;
   logic [N_CH-1:0]       press_pulse;
   logic [N_CH-1:0]       release_pulse;
   logic [N_CH*CNT_W-1:0] count;
   logic [N_CH-1:0]       wrap;

   debounce_event_counter #(
      .N_CH(N_CH), .PRESC_W(PRESC_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .cnt_en(cnt_en), .clr(clr),
      .sw_level(sw_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
      .count(count), .wrap(wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int ch;
      bit is_press;
      bit wrp;
   } ev_t;

   ev_t exp_q[$];
   ev_t e;

   int errors = 0;
   int checks = 0;
   int press_seen[N_CH];
   int release_seen[N_CH];
   int wrap_seen[N_CH];

   // reference model state
   int       m_edges = 0;
   bit [1:0] m_h1 = 2'b11;
   bit [1:0] m_h2 = 2'b11;
   bit [1:0] m_level = 2'b11;
   int       m_run[N_CH];
   int       m_cnt[N_CH];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Model: a level flips at a tick once the previous DEPTH tick samples all disagree with it
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edges = 0;
         m_h1 = 2'b11;
         m_h2 = 2'b11;
         m_level = 2'b11;
         for (int c = 0; c < N_CH; c++) begin
            m_run[c] = 0;
            m_cnt[c] = 0;
         end
         exp_q.delete();
      end else begin
         bit [1:0] s;
         ev_t ne;
         m_edges++;
         s = m_h2;
         if (clr) for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
         if (m_edges % TICK == 0) begin
            for (int c = 0; c < N_CH; c++) begin
               if (m_run[c] >= DEPTH) begin
                  m_level[c]  = ~m_level[c];
                  ne.ch       = c;
                  ne.is_press = (m_level[c] == 1'b0);
                  ne.wrp      = 1'b0;
                  if (ne.is_press && !clr && cnt_en) begin
                     ne.wrp   = (m_cnt[c] == 15);
                     m_cnt[c] = (m_cnt[c] + 1) % 16;
                  end
                  exp_q.push_back(ne);
               end
               m_run[c] = (s[c] != m_level[c]) ? m_run[c] + 1 : 0;
            end
         end
         m_h2 = m_h1;
         m_h1 = sw_in;
      end
   end

   // Monitor: every event expected for this cycle must appear now, and nothing else
   always @(negedge clk) begin
      if (rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            if (press_pulse[c] || release_pulse[c]) begin
               if (press_pulse[c]) press_seen[c]++;
               else                release_seen[c]++;
               if (wrap[c]) wrap_seen[c]++;
               chk("pulse_both", int'(press_pulse[c] & release_pulse[c]), 0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pulse: ch %0d press %0b release %0b with none expected at %0t",
                           c, press_pulse[c], release_pulse[c], $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("ev_ch", c, e.ch);
                  chk("ev_kind", int'(press_pulse[c]), int'(e.is_press));
                  chk("ev_wrap", int'(wrap[c]), int'(e.wrp));
               end
            end else begin
               chk("idle_wrap", int'(wrap[c]), 0);
            end
         end
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missed_pulse: got 0 pulses expected %0d at %0t", exp_q.size(), $time);
            exp_q.delete();
         end
         chk("level", int'(sw_level), int'(m_level));
         chk("count", int'(count), (m_cnt[1] << CNT_W) | m_cnt[0]);
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int c);
      sw_in[c] = 1'b0;
      wait_clk(70);
   endtask

   task automatic unpress(input int c);
      sw_in[c] = 1'b1;
      wait_clk(70);
   endtask

   int base_p;
   int base_r;
   int base_w;

   initial begin
      for (int c = 0; c < N_CH; c++) begin
         press_seen[c] = 0; release_seen[c] = 0; wrap_seen[c] = 0;
         m_run[c] = 0; m_cnt[c] = 0;
      end
      rst_n  = 1'b0;
      sw_in  = 2'b11;
      cnt_en = 1'b1;
      clr    = 1'b0;

      // 1: reset state, no pulse after release
      wait_clk(3);
      chk("rst_level", int'(sw_level), 3);
      chk("rst_count", int'(count), 0);
      chk("rst_pulses", int'({press_pulse, release_pulse, wrap}), 0);
      @(posedge clk); #2 rst_n = 1'b1;
      wait_clk(100);
      chk("rst_no_pulse", press_seen[0] + press_seen[1] + release_seen[0] + release_seen[1], 0);

      // 2: clean press and release on ch0
      base_p = press_seen[0]; base_r = release_seen[0];
      press(0);
      chk("t2_level0", int'(sw_level[0]), 0);
      chk("t2_press0", press_seen[0] - base_p, 1);
      chk("t2_count0", int'(count[3:0]), 1);
      chk("t2_count1", int'(count[7:4]), 0);
      unpress(0);
      chk("t2_release0", release_seen[0] - base_r, 1);
      chk("t2_count0_after", int'(count[3:0]), 1);

      // 3: chatter faster than the tick never qualifies
      base_p = press_seen[0]; base_r = release_seen[0];
      repeat (67) begin
         sw_in[0] = ~sw_in[0];
         wait_clk(3);
      end
      sw_in[0] = 1'b1;
      wait_clk(80);
      chk("t3_level0", int'(sw_level[0]), 1);
      chk("t3_press0", press_seen[0] - base_p, 0);
      chk("t3_release0", release_seen[0] - base_r, 0);
      chk("t3_count0", int'(count[3:0]), 1);

      // 4: sixteen presses on ch1 wrap the counter once
      base_w = wrap_seen[1];
      for (int k = 1; k <= 16; k++) begin
         press(1);
         if (k == 15) chk("t4_count15", int'(count[7:4]), 15);
         unpress(1);
      end
      chk("t4_count_wrapped", int'(count[7:4]), 0);
      chk("t4_wrap1", wrap_seen[1] - base_w, 1);
      chk("t4_count0_kept", int'(count[3:0]), 1);

      // 5: clr beats a simultaneous press; cnt_en=0 holds the counter
      repeat (6) begin
         press(0);
         unpress(0);
      end
      chk("t5_count7", int'(count[3:0]), 7);
      base_p = press_seen[0]; base_w = wrap_seen[0];
      clr = 1'b1;
      sw_in[0] = 1'b0;
      wait_clk(70);
      clr = 1'b0;
      chk("t5_clr_count", int'(count[3:0]), 0);
      chk("t5_clr_press", press_seen[0] - base_p, 1);
      chk("t5_clr_wrap", wrap_seen[0] - base_w, 0);
      unpress(0);
      cnt_en = 1'b0;
      base_p = press_seen[0];
      press(0);
      chk("t5_hold_press", press_seen[0] - base_p, 1);
      chk("t5_hold_count", int'(count[3:0]), 0);
      unpress(0);
      cnt_en = 1'b1;

      // 6: reset mid-debounce discards partial history
      base_p = press_seen[0];
      sw_in[0] = 1'b0;
      wait_clk(3 * TICK);
      @(posedge clk); #2 rst_n = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      sw_in[0] = 1'b1;
      wait_clk(80);
      chk("t6_press0", press_seen[0] - base_p, 0);
      chk("t6_count0", int'(count[3:0]), 0);

      // random phase: mixed short glitches and long holds, random cnt_en and clr
      repeat (60) begin
         int c;
         int dur;
         c = int'($urandom_range(0, 1));
         sw_in[c] = ~sw_in[c];
         cnt_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) begin
            clr = 1'b1;
            wait_clk(1);
            clr = 1'b0;
         end
         dur = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(45, 110));
         wait_clk(dur);
      end
      sw_in  = 2'b11;
      cnt_en = 1'b1;
      wait_clk(80);
      chk("final_level", int'(sw_level), 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
